// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage hazard bus: instruction/pipeline status from the datapath,
// stall, flush and forward controls plus event counters back from the controller.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       rs, rt;
    logic             use_rs, use_rt, id_mdu, id_jump;
    logic [4:0]       ern, mrn;
    logic             ewreg, em2reg, mwreg, mm2reg;
    logic             wpcir, dbubble, ebubble, mdu_busy;
    logic [1:0]       fwda, fwdb;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    modport master (
        output rs, rt, use_rs, use_rt, id_mdu, id_jump,
               ern, ewreg, em2reg, mrn, mwreg, mm2reg,
        input  wpcir, dbubble, ebubble, fwda, fwdb, mdu_busy, stall_cnt, flush_cnt
    );
    modport slave (
        input  rs, rt, use_rs, use_rt, id_mdu, id_jump,
               ern, ewreg, em2reg, mrn, mwreg, mm2reg,
        output wpcir, dbubble, ebubble, fwda, fwdb, mdu_busy, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Load-use / MDU stall, taken-branch flush and operand forwarding for the ID stage.
// One fwd_sel instance per source operand (rs, rt).
module fwd_sel (
    input  logic [4:0] src,
    input  logic [4:0] ern,
    input  logic [4:0] mrn,
    input  logic       ewreg,
    input  logic       em2reg,
    input  logic       mwreg,
    input  logic       mm2reg,
    output logic [1:0] sel
);
    always_comb begin
        sel = 2'b00;
        if (ewreg && !em2reg && ern != 5'd0 && ern == src)
            sel = 2'b01;
        else if (mwreg && !mm2reg && mrn != 5'd0 && mrn == src)
            sel = 2'b10;
        else if (mwreg && mm2reg && mrn != 5'd0 && mrn == src)
            sel = 2'b11;
    end
endmodule

module pipe_hazard_ctrl #(
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 16
) (
    input logic               clock,
    input logic               reset,
    pipe_hazard_ctrl_if.slave hz
);
    localparam int NUM_OPS = 2;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       ldhaz, stall;

    logic [NUM_OPS-1:0][4:0] src;
    logic [NUM_OPS-1:0][1:0] sel;

    assign src = {hz.rt, hz.rs};

    for (genvar g = 0; g < NUM_OPS; g++) begin : g_fwd
        fwd_sel u_fwd (
            .src    (src[g]),
            .ern    (hz.ern),
            .mrn    (hz.mrn),
            .ewreg  (hz.ewreg),
            .em2reg (hz.em2reg),
            .mwreg  (hz.mwreg),
            .mm2reg (hz.mm2reg),
            .sel    (sel[g])
        );
    end

    assign ldhaz = hz.ewreg && hz.em2reg && hz.ern != 5'd0 &&
                   ((hz.use_rs && hz.ern == hz.rs) || (hz.use_rt && hz.ern == hz.rt));
    assign stall = ldhaz || (state == BUSY);

    // Reset overrides every control so the pipeline free-runs cleanly out of reset.
    always_comb begin
        hz.wpcir    = 1'b1;
        hz.dbubble  = 1'b0;
        hz.ebubble  = 1'b0;
        hz.fwda     = 2'b00;
        hz.fwdb     = 2'b00;
        hz.mdu_busy = 1'b0;
        if (!reset) begin
            hz.wpcir    = !stall;
            hz.ebubble  = stall;
            hz.dbubble  = hz.id_jump && !stall;
            hz.fwda     = sel[0];
            hz.fwdb     = sel[1];
            hz.mdu_busy = (state == BUSY);
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: if (hz.id_mdu && !ldhaz) begin
                state_nxt = BUSY;
                cnt_nxt   = 4'(MDU_LAT - 1);
            end
            BUSY: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hz.stall_cnt <= '0;
            hz.flush_cnt <= '0;
        end else begin
            if (!hz.wpcir && hz.stall_cnt != '1) hz.stall_cnt <= hz.stall_cnt + 1'b1;
            if (hz.dbubble && hz.flush_cnt != '1) hz.flush_cnt <= hz.flush_cnt + 1'b1;
        end
    end
endmodule
